// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: architectural integer register file with a pending-write
// scoreboard. Writeback writes the array and clears pending. Issue marks a
// destination pending. Flush clears every pending bit. Two asynchronous read
// ports return data and busy flags. x0 reads as zero and is never busy.
// Optional feature macro: RAPID_REGFILE_BYPASS_EN forwards same-cycle writeback
// data to the read ports.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_valid,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_wb_done,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rd,
    input  logic            i_flush,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic             wb_hit;
    logic             issue_take;
    logic [AW-1:0]    rd_addr [2];
    logic [XLEN-1:0]  rd_data [2];
    logic             rd_busy [2];

    // An address is usable when it is neither x0 nor beyond the last register.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return (addr != '0) && (int'(addr) < NREGS);
    endfunction

    assign wb_hit     = i_wb_valid && addr_ok(i_wb_rd);
    assign issue_take = i_issue_valid && addr_ok(i_issue_rd) && !i_flush;

    assign rd_addr[0] = i_rs1_addr;
    assign rd_addr[1] = i_rs2_addr;
    assign o_rs1_data = rd_data[0];
    assign o_rs2_data = rd_data[1];
    assign o_rs1_busy = rd_busy[0];
    assign o_rs2_busy = rd_busy[1];

    // Next pending vector: writeback clears, a new issue re-arms, flush clears all.
    always_comb begin
        pending_next = pending;
        if (wb_hit) begin
            pending_next[i_wb_rd] = 1'b0;
        end
        if (issue_take) begin
            pending_next[i_issue_rd] = 1'b1;
        end
        if (i_flush) begin
            pending_next = '0;
        end
    end

    // State update: reset clears everything, otherwise write, ack and track pending.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending   <= '0;
            o_wb_done <= 1'b0;
        end else begin
            o_wb_done <= i_wb_valid;
            pending   <= pending_next;
            if (wb_hit) begin
                regs[i_wb_rd] <= i_wb_data;
            end
        end
    end

    // Read ports: stored value and pending bit, optionally bypassing a same-cycle writeback.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (addr_ok(rd_addr[p])) begin
                rd_data[p] = regs[rd_addr[p]];
                rd_busy[p] = pending[rd_addr[p]];
`ifdef RAPID_REGFILE_BYPASS_EN
                if (wb_hit && (i_wb_rd == rd_addr[p])) begin
                    rd_data[p] = i_wb_data;
                    rd_busy[p] = issue_take && (i_issue_rd == rd_addr[p]);
                end
`else
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: table-driven bench for regfile_scoreboard (default
// build, no bypass). Every row drives one cycle of inputs and checks the
// combinational read outputs against the state before that cycle's edge. A
// queue holds the expected o_wb_done values. Each driven writeback pushes one
// value, and the value is popped and compared one edge later. Hand-written
// sequences cover reset and a mid-stream reset.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_done;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;

    int checks = 0;
    int errors = 0;
    logic exp_done_q[$];

    typedef struct {
        logic            wb_valid;
        logic [AW-1:0]   wb_rd;
        logic [XLEN-1:0] wb_data;
        logic            issue_valid;
        logic [AW-1:0]   issue_rd;
        logic            flush;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [XLEN-1:0] e1d;
        logic            e1b;
        logic [XLEN-1:0] e2d;
        logic            e2b;
    } vec_t;

    vec_t vecs[16];

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_wb_data     (wb_data),
        .o_wb_done     (wb_done),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_flush       (flush),
        .i_rs1_addr    (rs1_addr),
        .i_rs2_addr    (rs2_addr),
        .o_rs1_data    (rs1_data),
        .o_rs2_data    (rs2_data),
        .o_rs1_busy    (rs1_busy),
        .o_rs2_busy    (rs2_busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic wv, input logic [AW-1:0] wr, input logic [XLEN-1:0] wd,
                                input logic iv, input logic [AW-1:0] ir, input logic fl,
                                input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [XLEN-1:0] d1, input logic b1,
                                input logic [XLEN-1:0] d2, input logic b2);
        vec_t v;
        v.wb_valid = wv; v.wb_rd = wr; v.wb_data = wd;
        v.issue_valid = iv; v.issue_rd = ir; v.flush = fl;
        v.rs1 = a1; v.rs2 = a2;
        v.e1d = d1; v.e1b = b1; v.e2d = d2; v.e2b = b2;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_done(input string name);
        logic exp;
        if (exp_done_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got %b expected queued value", name, wb_done);
        end else begin
            exp = exp_done_q.pop_front();
            checkOutput(name, {31'b0, wb_done}, {31'b0, exp});
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    // Drive one row just after an edge, check reads mid-cycle, check the ack after the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        reset = 1'b0;
        wb_valid = v.wb_valid; wb_rd = v.wb_rd; wb_data = v.wb_data;
        issue_valid = v.issue_valid; issue_rd = v.issue_rd; flush = v.flush;
        rs1_addr = v.rs1; rs2_addr = v.rs2;
        exp_done_q.push_back(v.wb_valid);
        #3;
        checkOutput($sformatf("v%0d rs1_data", idx), rs1_data, v.e1d);
        checkOutput($sformatf("v%0d rs1_busy", idx), {31'b0, rs1_busy}, {31'b0, v.e1b});
        checkOutput($sformatf("v%0d rs2_data", idx), rs2_data, v.e2d);
        checkOutput($sformatf("v%0d rs2_busy", idx), {31'b0, rs2_busy}, {31'b0, v.e2b});
        @(posedge clk);
        #1;
        check_done($sformatf("v%0d wb_done", idx));
    endtask

    task automatic check_all_clear(input string tag);
        for (int i = 1; i < NREGS; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(i);
            #1;
            checkOutput($sformatf("%s x%0d rs1_data", tag, i), rs1_data, '0);
            checkOutput($sformatf("%s x%0d rs1_busy", tag, i), {31'b0, rs1_busy}, '0);
            checkOutput($sformatf("%s x%0d rs2_data", tag, i), rs2_data, '0);
            checkOutput($sformatf("%s x%0d rs2_busy", tag, i), {31'b0, rs2_busy}, '0);
        end
    endtask

    initial begin
        //               wbv wbrd  wbdata        isv isrd fl  rs1 rs2  e1d           e1b e2d           e2b
        vecs[0]  = mk(0, 0,  32'h0,        1, 5, 0, 5,  0,  32'h0,        0, 32'h0,        0);
        vecs[1]  = mk(0, 0,  32'h0,        0, 0, 0, 5,  5,  32'h0,        1, 32'h0,        1);
        vecs[2]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 0, 5,  6,  32'h0,        1, 32'h0,        0);
        vecs[3]  = mk(0, 0,  32'h0,        0, 0, 0, 5,  5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        vecs[4]  = mk(1, 0,  32'hFFFFFFFF, 1, 0, 0, 0,  0,  32'h0,        0, 32'h0,        0);
        vecs[5]  = mk(0, 0,  32'h0,        0, 0, 0, 0,  0,  32'h0,        0, 32'h0,        0);
        vecs[6]  = mk(1, 7,  32'h12,       1, 7, 0, 7,  5,  32'h0,        0, 32'hDEADBEEF, 0);
        vecs[7]  = mk(0, 0,  32'h0,        1, 3, 0, 7,  3,  32'h12,       1, 32'h0,        0);
        vecs[8]  = mk(0, 0,  32'h0,        1, 9, 0, 3,  9,  32'h0,        1, 32'h0,        0);
        vecs[9]  = mk(0, 0,  32'h0,        1, 4, 1, 3,  9,  32'h0,        1, 32'h0,        1);
        vecs[10] = mk(0, 0,  32'h0,        0, 0, 0, 4,  9,  32'h0,        0, 32'h0,        0);
        vecs[11] = mk(0, 0,  32'h0,        0, 0, 0, 3,  7,  32'h0,        0, 32'h12,       0);
        vecs[12] = mk(1, 31, 32'hA5A5A5A5, 0, 0, 0, 31, 30, 32'h0,        0, 32'h0,        0);
        vecs[13] = mk(1, 30, 32'h1,        0, 0, 0, 31, 30, 32'hA5A5A5A5, 0, 32'h0,        0);
        vecs[14] = mk(1, 7,  32'h77,       0, 0, 1, 30, 7,  32'h1,        0, 32'h12,       0);
        vecs[15] = mk(0, 0,  32'h0,        0, 0, 0, 7,  30, 32'h77,       0, 32'h1,        0);

        reset = 1'b1;
        idle_inputs();
        rs1_addr = '0;
        rs2_addr = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset wb_done", {31'b0, wb_done}, '0);
        check_all_clear("reset");

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Mid-stream reset: arm x2 pending, then reset with a wb to x2 in flight.
        idle_inputs();
        issue_valid = 1'b1;
        issue_rd = 5'd2;
        exp_done_q.push_back(1'b0);
        @(posedge clk);
        #1;
        check_done("pre-reset wb_done");
        rs1_addr = 5'd2;
        #1;
        checkOutput("pre-reset x2 busy", {31'b0, rs1_busy}, 32'h1);

        reset = 1'b1;
        wb_valid = 1'b1;
        wb_rd = 5'd2;
        wb_data = 32'hCAFEF00D;
        issue_valid = 1'b1;
        issue_rd = 5'd8;
        exp_done_q.push_back(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        check_done("mid-reset wb_done");
        check_all_clear("midreset");

        if (exp_done_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d leftover entries expected 0", exp_done_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
